// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter: round-robin arbiter and sequencer that shares one
// 16-bit logic/arithmetic unit between two requesters. Each accepted
// request is latched, executed for one cycle, and returned as a registered,
// tagged result held until the consumer takes it.
// Optional build macro: ALU_ARB_STATS_EN adds saturating per-requester
// grant counters (grant_cnt0 / grant_cnt1).
module alu_logic_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOT  = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

  state_e           state_q, state_d;
  logic             last_grant;
  logic             winner;
  logic             accept;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_result;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    winner = req_valid[1] & (~req_valid[0] | ~last_grant);
  end

  // Next-state and handshake decode; req_ready depends only on state, req_valid, last_grant.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = winner ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shared logic/arithmetic unit operating on the latched operands.
  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_AND:  alu_result = a_q & b_q;
      OP_OR:   alu_result = a_q | b_q;
      OP_XOR:  alu_result = a_q ^ b_q;
      OP_NOR:  alu_result = ~(a_q | b_q);
      OP_NAND: alu_result = ~(a_q & b_q);
      OP_NOT:  alu_result = ~a_q;
      OP_ADD:  alu_result = a_q + b_q;
      OP_SUB:  alu_result = a_q - b_q;
      default: alu_result = '0;
    endcase
  end

  // State register, request capture and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= winner ? op_e'(req_op1) : op_e'(req_op0);
        a_q        <= winner ? req_a1 : req_a0;
        b_q        <= winner ? req_b1 : req_b0;
        id_q       <= winner;
        last_grant <= winner;
      end
      if (state_q == EXEC) begin
        rsp_data  <= alu_result;
        rsp_zero  <= (alu_result == '0);
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester accepted-request counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!winner && grant_cnt0 != '1) begin
        grant_cnt0 <= grant_cnt0 + 8'd1;
      end
      if (winner && grant_cnt1 != '1) begin
        grant_cnt1 <= grant_cnt1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Testbench for alu_logic_arbiter: a driver issues directed and random
// requests, predicts grants and response timing from a transaction-level
// model, and pushes expected results to a scoreboard that an independent
// monitor pops whenever a response is handed over.
module tb_alu_logic_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [2:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zero;
`ifdef ALU_ARB_STATS_EN
  logic [7:0]  grant_cnt0, grant_cnt1;
`endif

  alu_logic_arbiter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Requester/consumer model state owned by the driver.
  bit          v0, v1;
  logic [2:0]  o0, o1;
  logic [15:0] a0, b0, a1, b1;
  bit          rdy;
  bit          busy;
  int          age;
  bit          last_g;
  int          cnt0_m, cnt1_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Operation semantics from the op-code table, in plain integer arithmetic.
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r  = 0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: r = 65535 - (ua | ub);
      3'd4: r = 65535 - (ua & ub);
      3'd5: r = 65535 - ua;
      3'd6: r = (ua + ub) % 65536;
      default: r = (ua + 65536 - ub) % 65536;
    endcase
    return r[15:0];
  endfunction

  // One clock cycle: drive, check grant and response-valid timing, update model.
  task automatic cycle();
    logic [1:0] exp_rdy;
    bit         win;
    bit         exp_rv;
    @(negedge clk);
    #1;
    req_valid = {v1, v0};
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    rsp_ready = rdy;
    #1;
    exp_rdy = 2'b00;
    win     = 1'b0;
    if (!busy && (v0 || v1)) begin
      win     = (v0 && v1) ? !last_g : v1;
      exp_rdy = win ? 2'b10 : 2'b01;
    end
    chk("req_ready", req_ready, exp_rdy);
    exp_rv = busy && (age >= 2);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (busy) begin
      if (exp_rv && rdy) busy = 1'b0;
      else age++;
    end else if (exp_rdy != 2'b00) begin
      sb.push_back('{id: win, data: win ? alu_ref(o1, a1, b1) : alu_ref(o0, a0, b0)});
      busy   = 1'b1;
      age    = 1;
      last_g = win;
      if (win) begin v1 = 1'b0; cnt1_m++; end
      else     begin v0 = 1'b0; cnt0_m++; end
    end
  endtask

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while ((busy || v0 || v1) && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    if (busy || v0 || v1) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
      v0 = 1'b0; v1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    busy = 1'b0; age = 0; last_g = 1'b1; rdy = 1'b1;
    cnt0_m = 0; cnt1_m = 0;
  endtask

  task automatic set0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    v0 = 1'b1; o0 = op; a0 = a; b0 = b;
  endtask

  task automatic set1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    v1 = 1'b1; o1 = op; a1 = a; b1 = b;
  endtask

  function automatic int sat(input int c);
    return (c > 255) ? 255 : c;
  endfunction

  // Monitor: pops the scoreboard on each response handshake and checks hold stability.
  bit          held = 1'b0;
  logic [15:0] h_data;
  logic        h_id, h_zero;
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (reset) begin
      held = 1'b0;
    end else if (rsp_valid) begin
      if (held) begin
        chk("hold_data", rsp_data, h_data);
        chk("hold_id", rsp_id, h_id);
        chk("hold_zero", rsp_zero, h_zero);
      end
      if (rsp_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_zero", rsp_zero, e.data == 16'h0000);
        end
      end else begin
        held = 1'b1; h_data = rsp_data; h_id = rsp_id; h_zero = rsp_zero;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    o0 = '0; o1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_zero", rsp_zero, 0);
    chk("reset_req_ready", req_ready, 0);

    // Single OR from requester 0.
    set0(3'd1, 16'h1082, 16'h4648);
    run_idle(20);

    // Tie from the cycle after reset, then a further tie.
    do_reset();
    set0(3'd0, 16'hA4F1, 16'h1082);
    set1(3'd2, 16'hFFFF, 16'h00FF);
    run_idle(20);
    set0(3'd6, 16'h1234, 16'h1111);
    set1(3'd4, 16'hF0F0, 16'hFF00);
    run_idle(20);

    // Backpressure: response held 5 cycles while another request waits.
    rdy = 1'b0;
    set0(3'd3, 16'h0F00, 16'h00F0);
    cycle();
    set1(3'd7, 16'h8000, 16'h0001);
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    rdy = 1'b1;
    run_idle(20);

    // Arithmetic and NOT boundaries.
    set0(3'd6, 16'hFFFF, 16'h0001);
    run_idle(20);
    set1(3'd7, 16'h0000, 16'h0001);
    run_idle(20);
    set0(3'd5, 16'h0F0F, 16'hABCD);
    run_idle(20);

    // Reset during EXEC abandons the operation.
    set0(3'd1, 16'h00FF, 16'hFF00);
    set1(3'd2, 16'h1111, 16'h2222);
    cycle();
    do_reset();
    chk("midreset_rsp_valid", rsp_valid, 0);
`ifdef ALU_ARB_STATS_EN
    chk("midreset_cnt0", grant_cnt0, 0);
    chk("midreset_cnt1", grant_cnt1, 0);
`endif
    set0(3'd2, 16'hAAAA, 16'h5555);
    set1(3'd0, 16'hAAAA, 16'h5555);
    run_idle(20);

    // Random traffic with withdrawals and random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!v0 && ($urandom % 3 == 0)) set0(3'($urandom), 16'($urandom), 16'($urandom));
      if (!v1 && ($urandom % 3 == 0)) set1(3'($urandom), 16'($urandom), 16'($urandom));
      if (busy && v0 && ($urandom % 8 == 0)) v0 = 1'b0;
      if (busy && v1 && ($urandom % 8 == 0)) v1 = 1'b0;
      rdy = ($urandom % 4) != 0;
      cycle();
    end
    rdy = 1'b1;
    run_idle(40);
`ifdef ALU_ARB_STATS_EN
    chk("rand_cnt0", grant_cnt0, sat(cnt0_m));
    chk("rand_cnt1", grant_cnt1, sat(cnt1_m));

    // Saturation: 300 requests from requester 1 only.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set1(3'($urandom), 16'($urandom), 16'($urandom));
      run_idle(10);
    end
    chk("sat_cnt1", grant_cnt1, sat(cnt1_m));
    chk("sat_cnt0", grant_cnt0, sat(cnt0_m));
`endif

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
